// File: rtl/alu_result_pkg.sv
// Shared constants for the ALU result queue: flag layout and default geometry.
package alu_result_pkg;

  localparam int unsigned FLAG_W = 4;

  // Flags travel as {N,Z,C,V}, N in the MSB.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer/consumer bundle for alu_result_queue; master drives requests, slave is the queue.
interface alu_result_queue_if
  import alu_result_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);

  logic                         clear;
  logic                         alu_out_write;
  logic [WIDTH-1:0]             result;
  logic [FLAG_W-1:0]            flags_in;
  logic                         result_ready;
  logic                         result_valid;
  logic [WIDTH-1:0]             result_out;
  logic [FLAG_W-1:0]            flags_out;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         full;
  logic                         empty;
  logic                         overflow_err;

  modport master (
    output clear, alu_out_write, result, flags_in, result_ready,
    input  result_valid, result_out, flags_out, count, full, empty, overflow_err
  );

  modport slave (
    input  clear, alu_out_write, result, flags_in, result_ready,
    output result_valid, result_out, flags_out, count, full, empty, overflow_err
  );

endinterface

// File: rtl/alu_result_mem.sv
// Entry storage for the result queue: one synchronous write port, one async read port.
module alu_result_mem #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [DataW-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [DataW-1:0]         rdata
);

  // Contents are deliberately not reset; the queue masks them while empty.
  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// FIFO of ALU results with sticky overflow flag and synchronous clear.
// Define ALU_RESULT_FLAGS_EN to store {N,Z,C,V} flags alongside each result.
module alu_result_queue
  import alu_result_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  alu_result_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
`ifdef ALU_RESULT_FLAGS_EN
  localparam int unsigned EntW = WIDTH + FLAG_W;
`else
  localparam int unsigned EntW = WIDTH;
`endif

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            is_empty, is_full;
  logic            pop, push, drop, mem_we;
  logic [EntW-1:0] wr_data, rd_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CntW'(DEPTH));

  always_comb begin
    pop      = !is_empty && bus.result_ready;
    push     = bus.alu_out_write && (!is_full || pop);
    drop     = bus.alu_out_write && is_full && !pop;
    mem_we   = push && !bus.clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef ALU_RESULT_FLAGS_EN
  assign wr_data = {bus.flags_in, bus.result};
`else
  assign wr_data = bus.result;
`endif

  alu_result_mem #(
    .DataW (EntW),
    .Depth (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    bus.result_valid = !is_empty;
    bus.count        = count_q;
    bus.full         = is_full;
    bus.empty        = is_empty;
    bus.overflow_err = ovf_q;
    bus.result_out   = is_empty ? '0 : rd_data[WIDTH-1:0];
`ifdef ALU_RESULT_FLAGS_EN
    bus.flags_out    = is_empty ? '0 : rd_data[EntW-1 -: FLAG_W];
`else
    bus.flags_out    = '0;
`endif
  end

endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 Parameter WIDTH, default 32, data bits per entry.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of all entries and the error flag.
REQ-006 alu_out_write  input  1  push request for result/flags_in.
REQ-007 result  input  WIDTH  ALU result to enqueue.
REQ-008 flags_in  input  4  ALU flags {N,Z,C,V}, index order from package.
REQ-009 result_ready  input  1  consumer accepts head entry this cycle.
REQ-010 result_valid  output  1  head entry present (equals !empty).
REQ-011 result_out  output  WIDTH  head entry data; 0 when empty.
REQ-012 flags_out  output  4  head entry flags; 0 when empty.
REQ-013 count  output  $clog2(DEPTH+1)  entries held, 0..DEPTH.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 overflow_err  output  1  sticky: a push was dropped.

Function
REQ-017 Pop SHALL occur when result_valid && result_ready; pop on empty SHALL be ignored.
REQ-018 Push SHALL be accepted when alu_out_write && (!full || pop in same cycle).
REQ-019 Push while full without same-cycle pop SHALL be dropped, storage unchanged, overflow_err set at next edge.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, at any fill level including full and (with one entry) near-empty.
REQ-021 Ordering SHALL be strict FIFO; write and read pointers SHALL wrap modulo DEPTH.
REQ-022 Latency: value pushed at edge N into an empty queue SHALL appear on result_out/result_valid after edge N (no combinational bypass from result to result_out).
REQ-023 After a pop at edge N, the next entry (or 0 if none) SHALL be presented after edge N.
REQ-024 clear SHALL take priority over push and pop in the same cycle: pointers, count, overflow_err go to 0; the concurrent push is discarded.
REQ-025 full, empty, result_valid SHALL be derived from registered count, glitch-free relative to clk.
REQ-026 overflow_err SHALL remain 1 until reset or clear, regardless of later pops.

Reset
REQ-027 On reset assertion, immediately and independently of clk: count=0, pointers=0, overflow_err=0, empty=1, full=0, result_valid=0, result_out=0, flags_out=0.
REQ-028 Storage array contents need not be reset; they SHALL never be visible while empty.
REQ-029 Reset asserted mid-operation SHALL discard all entries; first push after deassertion behaves as on an empty queue.

Configuration
REQ-030 Macro ALU_RESULT_FLAGS_EN: when defined, flags_in SHALL be stored per entry and returned on flags_out alongside result_out.
REQ-031 When ALU_RESULT_FLAGS_EN is undefined, no flag storage SHALL be built, flags_in SHALL be ignored, flags_out SHALL be constant 0; ports remain present.

Structure
REQ-032 Package alu_result_pkg SHALL hold FLAG_W=4, flag bit indices (FLAG_N, FLAG_Z, FLAG_C, FLAG_V) and default WIDTH/DEPTH constants.
REQ-033 Storage SHALL be a sub-module alu_result_mem (DEPTH x (WIDTH+flag bits), one write port, one async read port); pointer/count control stays in alu_result_queue.

Verification
REQ-034 Reset, push 32'h12345678 -> after one edge result_valid=1, result_out=32'h12345678, count=1.
REQ-035 Push 25,10,32'h00FF00FF,32'h55555555 with ready=0 -> full=1, count=4; then ready=1 for 4 cycles -> outputs 25,10,32'h00FF00FF,32'h55555555 in order, then empty=1, result_out=0.
REQ-036 Full queue, push 32'hABCDEF01 with ready=0 -> dropped, overflow_err=1, count=4; push with ready=1 same cycle -> accepted, count stays 4, last entry 32'hABCDEF01.
REQ-037 Three entries held, assert clear with push 32'h87654321 -> count=0, empty=1, overflow_err=0, no entry stored.
REQ-038 With ALU_RESULT_FLAGS_EN, push result 0 with flags_in=4'b0100 -> flags_out=4'b0100; without macro flags_out=0.
REQ-039 Push/pop each cycle over 2*DEPTH+1 cycles -> pointers wrap, data matches, count constant 1; async reset mid-run clears outputs before next clk edge.
